// File: rtl/id_stage_pkg.sv
// RV32I shared definitions: widths, opcode constants and the operation class
// produced by the decode stage.
package risc_v_32i;

  localparam int REG_WIDTH = 5;
  localparam int REG_SIZE  = 32;
  localparam int XLEN      = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Encoding 0 is LUI so that a reset ID/EX register reads as LUI.
  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd11
  } op_class_t;

endpackage

// File: rtl/id_stage_if.sv
// Fetch / register-file / writeback / execute signals seen by the decode stage.
// master = surrounding pipeline, slave = id_stage.
interface id_stage_if;
  import risc_v_32i::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_instr;
  logic [XLEN-1:0]      in_pc;
  logic [REG_WIDTH-1:0] rs1_addr;
  logic [REG_WIDTH-1:0] rs2_addr;
  logic [REG_SIZE-1:0]  rs1_read;
  logic [REG_SIZE-1:0]  rs2_read;
  logic                 wb_enable;
  logic [REG_WIDTH-1:0] wb_addr;
  logic [REG_SIZE-1:0]  wb_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [XLEN-1:0]      out_rs1_val;
  logic [XLEN-1:0]      out_rs2_val;
  logic [XLEN-1:0]      out_imm;
  logic [REG_WIDTH-1:0] out_rs1_addr;
  logic [REG_WIDTH-1:0] out_rs2_addr;
  logic [REG_WIDTH-1:0] out_rd;
  op_class_t            out_op;
  logic [2:0]           out_funct3;
  logic                 out_funct7b5;

  modport master (
    output in_valid, in_instr, in_pc, rs1_read, rs2_read,
           wb_enable, wb_addr, wb_data, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_rs1_val,
           out_rs2_val, out_imm, out_rs1_addr, out_rs2_addr, out_rd,
           out_op, out_funct3, out_funct7b5
  );

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_read, rs2_read,
           wb_enable, wb_addr, wb_data, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_rs1_val,
           out_rs2_val, out_imm, out_rs1_addr, out_rs2_addr, out_rd,
           out_op, out_funct3, out_funct7b5
  );

endinterface

// File: rtl/id_stage_decoder.sv
// Combinational RV32I instruction decoder: op class, register fields,
// funct bits and the sign-extended immediate for each format.
module instr_decoder
  import risc_v_32i::*;
(
  input  logic [XLEN-1:0]      i_instr,
  output op_class_t            o_op,
  output logic [REG_WIDTH-1:0] o_rd,
  output logic [REG_WIDTH-1:0] o_rs1,
  output logic [REG_WIDTH-1:0] o_rs2,
  output logic [2:0]           o_funct3,
  output logic                 o_funct7b5,
  output logic [XLEN-1:0]      o_imm
);

  op_class_t       w_op;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'h000};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};

  // Classify the opcode; compressed-space encodings (low bits != 11) are illegal.
  always_comb begin
    w_op = CLS_ILLEGAL;
    if (i_instr[1:0] == 2'b11) begin
      case (i_instr[6:0])
        OPC_LUI:    w_op = CLS_LUI;
        OPC_AUIPC:  w_op = CLS_AUIPC;
        OPC_JAL:    w_op = CLS_JAL;
        OPC_JALR:   w_op = CLS_JALR;
        OPC_BRANCH: w_op = CLS_BRANCH;
        OPC_LOAD:   w_op = CLS_LOAD;
        OPC_STORE:  w_op = CLS_STORE;
        OPC_OP_IMM: w_op = CLS_OP_IMM;
        OPC_OP:     w_op = CLS_OP;
        OPC_FENCE:  w_op = CLS_FENCE;
        OPC_SYSTEM: w_op = CLS_SYSTEM;
        default:    w_op = CLS_ILLEGAL;
      endcase
    end
  end

  // Select immediate format and mask rd/rs2 for formats that do not use them.
  always_comb begin
    o_imm = '0;
    o_rd  = i_instr[11:7];
    o_rs2 = '0;
    case (w_op)
      CLS_LUI, CLS_AUIPC:                      o_imm = w_imm_u;
      CLS_JAL:                                 o_imm = w_imm_j;
      CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_SYSTEM: o_imm = w_imm_i;
      CLS_BRANCH: begin
        o_imm = w_imm_b;
        o_rd  = '0;
        o_rs2 = i_instr[24:20];
      end
      CLS_STORE: begin
        o_imm = w_imm_s;
        o_rd  = '0;
        o_rs2 = i_instr[24:20];
      end
      CLS_OP:      o_rs2 = i_instr[24:20];
      CLS_ILLEGAL: o_rd  = '0;
      default:     o_imm = '0;
    endcase
  end

  assign o_op       = w_op;
  assign o_rs1      = i_instr[19:15];
  assign o_funct3   = i_instr[14:12];
  assign o_funct7b5 = i_instr[30];

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: valid/ready handshake, register-file address
// drive, operand capture and the ID/EX output register.
// Optional feature macro: ID_WB_BYPASS_EN (writeback-to-decode operand bypass).
module id_stage
  import risc_v_32i::*;
(
  input  logic      clk,
  input  logic      rst,
  id_stage_if.slave io_bus
);

  op_class_t            w_op;
  logic [REG_WIDTH-1:0] w_rd, w_rs1, w_rs2;
  logic [2:0]           w_funct3;
  logic                 w_funct7b5;
  logic [XLEN-1:0]      w_imm;
  logic                 w_in_ready, w_accept;
  logic [REG_SIZE-1:0]  w_rs1_in, w_rs2_in, w_rs1_hold, w_rs2_hold;

  logic                 r_valid;
  logic [XLEN-1:0]      r_pc, r_imm;
  logic [REG_SIZE-1:0]  r_rs1_val, r_rs2_val;
  logic [REG_WIDTH-1:0] r_rs1_addr, r_rs2_addr, r_rd;
  op_class_t            r_op;
  logic [2:0]           r_funct3;
  logic                 r_funct7b5;

  instr_decoder u_dec (
    .i_instr    (io_bus.in_instr),
    .o_op       (w_op),
    .o_rd       (w_rd),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_funct3   (w_funct3),
    .o_funct7b5 (w_funct7b5),
    .o_imm      (w_imm)
  );

  // Register-file addresses come straight from the raw fields so the read
  // data is available at the accepting edge.
  assign io_bus.rs1_addr = io_bus.in_instr[19:15];
  assign io_bus.rs2_addr = io_bus.in_instr[24:20];

  assign w_in_ready = !r_valid || io_bus.out_ready;
  assign w_accept   = io_bus.in_valid && w_in_ready && !io_bus.flush;

`ifdef ID_WB_BYPASS_EN
  // A same-edge writeback is newer than the regfile read; x0 is never forwarded.
  assign w_rs1_in = (io_bus.wb_enable && (io_bus.wb_addr != '0) &&
                     (io_bus.wb_addr == io_bus.rs1_addr)) ? io_bus.wb_data : io_bus.rs1_read;
  assign w_rs2_in = (io_bus.wb_enable && (io_bus.wb_addr != '0) &&
                     (io_bus.wb_addr == io_bus.rs2_addr)) ? io_bus.wb_data : io_bus.rs2_read;
  assign w_rs1_hold = (io_bus.wb_enable && (io_bus.wb_addr != '0) &&
                       (io_bus.wb_addr == r_rs1_addr)) ? io_bus.wb_data : r_rs1_val;
  assign w_rs2_hold = (io_bus.wb_enable && (io_bus.wb_addr != '0) &&
                       (io_bus.wb_addr == r_rs2_addr)) ? io_bus.wb_data : r_rs2_val;
`else
  logic w_unused_wb;
  assign w_rs1_in    = io_bus.rs1_read;
  assign w_rs2_in    = io_bus.rs2_read;
  assign w_rs1_hold  = r_rs1_val;
  assign w_rs2_hold  = r_rs2_val;
  assign w_unused_wb = ^{io_bus.wb_enable, io_bus.wb_addr, io_bus.wb_data};
`endif

  // ID/EX register: reset > flush > accept > drain > stall (operand refresh only).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd       <= '0;
      r_op       <= CLS_LUI;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
    end else if (io_bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= io_bus.in_pc;
      r_imm      <= w_imm;
      r_rs1_val  <= w_rs1_in;
      r_rs2_val  <= w_rs2_in;
      r_rs1_addr <= w_rs1;
      r_rs2_addr <= w_rs2;
      r_rd       <= w_rd;
      r_op       <= w_op;
      r_funct3   <= w_funct3;
      r_funct7b5 <= w_funct7b5;
    end else if (w_in_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_rs1_val <= w_rs1_hold;
      r_rs2_val <= w_rs2_hold;
    end
  end

  assign io_bus.in_ready     = w_in_ready;
  assign io_bus.out_valid    = r_valid;
  assign io_bus.out_pc       = r_pc;
  assign io_bus.out_rs1_val  = r_rs1_val;
  assign io_bus.out_rs2_val  = r_rs2_val;
  assign io_bus.out_imm      = r_imm;
  assign io_bus.out_rs1_addr = r_rs1_addr;
  assign io_bus.out_rs2_addr = r_rs2_addr;
  assign io_bus.out_rd       = r_rd;
  assign io_bus.out_op       = r_op;
  assign io_bus.out_funct3   = r_funct3;
  assign io_bus.out_funct7b5 = r_funct7b5;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode pipeline stage of the RV32I core, directly upstream of the register file. It accepts one fetched instruction per cycle over a valid/ready handshake and drives `rs1_addr`/`rs2_addr` to the register file. In the same cycle it captures the returned operands, together with the decoded immediate, destination and operation class, into an ID/EX output register. Stall, flush and writeback-to-decode bypass are handled locally.

## Interface
Parameters (from package `risc_v_32i`):
- REG_WIDTH, 5, register address width
- REG_SIZE, 32, register data width
- XLEN, 32, instruction and PC width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  XLEN  instruction word
- in_pc  in  XLEN  instruction address
- rs1_addr  out  REG_WIDTH  to register file, combinational from `in_instr[19:15]`
- rs2_addr  out  REG_WIDTH  to register file, combinational from `in_instr[24:20]`
- rs1_read  in  REG_SIZE  register file read data
- rs2_read  in  REG_SIZE  register file read data
- wb_enable  in  1  writeback write enable, same signal as the regfile `write_enable`
- wb_addr  in  REG_WIDTH  writeback address
- wb_data  in  REG_SIZE  writeback data
- flush  in  1  discard the held instruction and the incoming instruction
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute consumes it
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN each  decoded payload
- out_rs1_addr, out_rs2_addr, out_rd  out  REG_WIDTH each
- out_op  out  op_class_t  LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE/OP_IMM/OP/FENCE/SYSTEM/ILLEGAL
- out_funct3  out  3;  out_funct7b5  out  1

## Operation
- `in_ready = !out_valid || out_ready`. An instruction is accepted when `in_valid && in_ready && !flush`.
- On acceptance, all `out_*` fields load from the decoder and the register file; `out_valid <= 1`.
- Output consumed with no new acceptance: `out_valid <= 0`. Payload is retained but is don't-care.
- Stall (`out_valid && !out_ready`): every `out_*` field holds. Only `out_rs*_val` may change (see Configuration).
- Flush has priority over everything else: `out_valid <= 0` next cycle, and the incoming instruction is dropped even when `in_valid` is high.
- Immediate formats, all sign-extended to 32 bits:
  - I: JALR, LOAD, OP_IMM, SYSTEM
  - S: STORE
  - B: BRANCH, bit 0 = 0
  - U: LUI, AUIPC, low 12 bits = 0
  - J: JAL, bit 0 = 0
  - R and FENCE: immediate is 0
- `out_rd` is forced to 0 for BRANCH and STORE. `out_rs2_addr` is forced to 0 for formats that do not read rs2.
- Any opcode outside RV32I, or `in_instr[1:0] != 2'b11`, decodes to ILLEGAL. It still flows through the stage with rd = 0.

## Timing
- Reset: `out_valid = 0`. All `out_*` data fields are 0, and `out_op` is the encoding 0 (LUI). `in_ready = 1` one cycle after reset.
- Latency is 1 cycle. Accepted at edge N means visible on `out_*` after edge N.
- Throughput is 1 instruction per cycle while `out_ready = 1`.
- The register file read is combinational, so operands are sampled at the same edge that accepts the instruction.
- A reset asserted mid-stall discards the held instruction. `rst` and `flush` together behave as `rst`.

## Configuration
- `ID_WB_BYPASS_EN` defined:
  - On acceptance, if `wb_enable && wb_addr != 0 && wb_addr == rs1_addr`, `out_rs1_val` takes `wb_data` instead of `rs1_read`. The same rule applies to rs2.
  - While stalled, a writeback matching `out_rs1_addr`/`out_rs2_addr` (address non-zero) updates the held value on that edge.
- `ID_WB_BYPASS_EN` undefined:
  - Operands come only from `rs1_read`/`rs2_read`, and held values never change.
  - The hazard unit must then stall one extra cycle on writeback-to-decode hazards.

## Structure
- Package `risc_v_32i` holds:
  - `op_class_t` enum
  - RV32I opcode constants (OPC_LUI = 7'b0110111, ...)
  - `XLEN`, alongside the existing `REG_WIDTH`/`REG_SIZE`
- Sub-module `instr_decoder` is purely combinational: instruction in; op class, rd/rs1/rs2, funct fields and immediate out.
- `id_stage` owns the handshake, the bypass muxes and the ID/EX register.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid = 1` -> `out_valid = 0`, all fields 0, no acceptance.
- `addi x5,x1,-3` (0xFFD08293), `x1 = 10` -> next cycle `out_op = OP_IMM`, `out_rd = 5`, `out_imm = 0xFFFFFFFD`, `out_rs1_val = 10`.
- `beq` with offset -8, back-to-back with `sw`, `out_ready = 1` -> B and S immediates correct, `out_rd = 0` for both, one instruction per cycle.
- `out_ready = 0` for 3 cycles with new `in_valid` -> `in_ready = 0`, payload stable. A writeback to `x1 = 0x55` during the stall -> `out_rs1_val = 0x55` with the bypass macro, unchanged without it.
- Accept `add x3,x1,x2` while `wb_enable = 1`, `wb_addr = 2`, `wb_data = 7` -> `out_rs2_val = 7` with the macro. A writeback to x0 is never bypassed.
- `flush` concurrent with `in_valid` and a held instruction -> `out_valid = 0` next cycle, and both instructions are lost. Opcode 0x0000007F -> ILLEGAL.
